// File: rtl/life_scan_controller.sv
// Game-of-Life generation scan: walks the grid in raster order, issues 3x3
// neighbour reads across 9 interleaved banks, then delayed centre writes.
module life_scan_controller #(
    parameter int WIDTH_BLOCKS  = 2,
    parameter int HEIGHT_BLOCKS = 2,
    parameter int ADDR_WIDTH    = 2,
    parameter int WRAP_EDGES    = 0,
    parameter int WRITE_LATENCY = 2,
    parameter int GEN_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    advance,
    output logic                    busy,
    output logic                    done,
    output logic                    read_valid,
    output logic [8:0]              read_enable,
    output logic [9*ADDR_WIDTH-1:0] read_addr,
    output logic [8:0]              write_enable,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic                    frame_buffer_select,
    output logic [GEN_WIDTH-1:0]    generation
);
    localparam int XW = (WIDTH_BLOCKS > 1) ? $clog2(WIDTH_BLOCKS) : 1;
    localparam int YW = (HEIGHT_BLOCKS > 1) ? $clog2(HEIGHT_BLOCKS) : 1;
    localparam int L  = WRITE_LATENCY;
    localparam logic [XW-1:0] XMAX = XW'(WIDTH_BLOCKS - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT_BLOCKS - 1);
    localparam logic [L-1:0]  HEAD = L'(1) << (L - 1);
    localparam logic          WRAP = (WRAP_EDGES != 0);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;
    state_e state_q, state_d;

    // Pixel coordinate kept as (block, offset-in-block) pairs so no division is needed.
    logic [1:0]    sx_q, sx_d, sy_q, sy_d;
    logic [XW-1:0] bx_q, bx_d;
    logic [YW-1:0] by_q, by_d;

    logic                         read_valid_q;
    logic [8:0]                   read_enable_q;
    logic [8:0][ADDR_WIDTH-1:0]   read_addr_q;
    logic [8:0]                   ctr_oh_q;
    logic [ADDR_WIDTH-1:0]        ctr_addr_q;
    logic [L-1:0]                 vld_pipe_q;
    logic [L-1:0][8:0]            oh_pipe_q;
    logic [L-1:0][ADDR_WIDTH-1:0] addr_pipe_q;
    logic                         done_q, fsel_q;
    logic [GEN_WIDTH-1:0]         gen_q;

    logic issue, last_cell, drain_last;
    assign issue      = (state_q == SCAN) && advance;
    assign last_cell  = (sx_q == 2'd2) && (bx_q == XMAX) && (sy_q == 2'd2) && (by_q == YMAX);
    // Only the head stage may still hold work: the last write issues this cycle.
    assign drain_last = !read_valid_q && ((vld_pipe_q & ~HEAD) == '0);

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !done_q)     state_d = SCAN;
            SCAN:    if (issue && last_cell)   state_d = DRAIN;
            DRAIN:   if (drain_last)           state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        sx_d = sx_q; bx_d = bx_q; sy_d = sy_q; by_d = by_q;
        if (issue) begin
            if (sx_q != 2'd2) sx_d = sx_q + 2'd1;
            else begin
                sx_d = 2'd0;
                if (bx_q != XMAX) bx_d = bx_q + XW'(1);
                else begin
                    bx_d = '0;
                    if (sy_q != 2'd2) sy_d = sy_q + 2'd1;
                    else begin
                        sy_d = 2'd0;
                        by_d = (by_q == YMAX) ? '0 : by_q + YW'(1);
                    end
                end
            end
        end
    end

    // Per bank column/row: which block the neighbour falls in and whether it is on-grid.
    logic [2:0][XW-1:0] nbx;
    logic [2:0][YW-1:0] nby;
    logic [2:0]         nvx, nvy;
    logic [1:0]         xp, xm, yp, ym;
    always_comb begin
        xp = (sx_q == 2'd2) ? 2'd0 : sx_q + 2'd1;
        xm = (sx_q == 2'd0) ? 2'd2 : sx_q - 2'd1;
        yp = (sy_q == 2'd2) ? 2'd0 : sy_q + 2'd1;
        ym = (sy_q == 2'd0) ? 2'd2 : sy_q - 2'd1;
        for (int c = 0; c < 3; c++) begin
            nbx[c] = bx_q;
            nvx[c] = 1'b1;
            if (2'(c) == xp && sx_q == 2'd2) begin
                if (bx_q == XMAX) begin nbx[c] = '0; nvx[c] = WRAP; end
                else nbx[c] = bx_q + XW'(1);
            end else if (2'(c) == xm && sx_q == 2'd0) begin
                if (bx_q == '0) begin nbx[c] = XMAX; nvx[c] = WRAP; end
                else nbx[c] = bx_q - XW'(1);
            end
            nby[c] = by_q;
            nvy[c] = 1'b1;
            if (2'(c) == yp && sy_q == 2'd2) begin
                if (by_q == YMAX) begin nby[c] = '0; nvy[c] = WRAP; end
                else nby[c] = by_q + YW'(1);
            end else if (2'(c) == ym && sy_q == 2'd0) begin
                if (by_q == '0) begin nby[c] = YMAX; nvy[c] = WRAP; end
                else nby[c] = by_q - YW'(1);
            end
        end
    end

    logic [8:0]                 en_c;
    logic [8:0][ADDR_WIDTH-1:0] addr_c;
    logic [3:0]                 ctr_bank;
    always_comb begin
        for (int b = 0; b < 9; b++) begin
            en_c[b]   = nvx[b % 3] & nvy[b / 3];
            addr_c[b] = en_c[b] ? ADDR_WIDTH'(nby[b / 3]) * ADDR_WIDTH'(WIDTH_BLOCKS)
                                  + ADDR_WIDTH'(nbx[b % 3]) : '0;
        end
        ctr_bank = {2'b00, sy_q} * 4'd3 + {2'b00, sx_q};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sx_q <= '0; bx_q <= '0; sy_q <= '0; by_q <= '0;
            read_valid_q <= 1'b0; read_enable_q <= '0; read_addr_q <= '0;
            ctr_oh_q <= '0; ctr_addr_q <= '0;
            vld_pipe_q <= '0; oh_pipe_q <= '0; addr_pipe_q <= '0;
        end else begin
            sx_q <= sx_d; bx_q <= bx_d; sy_q <= sy_d; by_q <= by_d;
            read_valid_q <= issue;
            if (issue) begin
                read_enable_q <= en_c;
                read_addr_q   <= addr_c;
                ctr_oh_q      <= 9'(1) << ctr_bank;
                ctr_addr_q    <= ADDR_WIDTH'(by_q) * ADDR_WIDTH'(WIDTH_BLOCKS) + ADDR_WIDTH'(bx_q);
            end else begin
                read_enable_q <= '0;
            end
            // Free-running write delay line; never stalled by advance.
            vld_pipe_q[0]  <= read_valid_q;
            oh_pipe_q[0]   <= ctr_oh_q;
            addr_pipe_q[0] <= ctr_addr_q;
            for (int k = 1; k < L; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                oh_pipe_q[k]   <= oh_pipe_q[k-1];
                addr_pipe_q[k] <= addr_pipe_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            done_q <= 1'b0; fsel_q <= 1'b0; gen_q <= '0;
        end else begin
            done_q <= (state_q == DRAIN) && drain_last;
            if ((state_q == DRAIN) && drain_last) begin
                fsel_q <= ~fsel_q;
                gen_q  <= gen_q + GEN_WIDTH'(1);
            end
        end
    end

    assign done                = done_q;
    assign read_valid          = read_valid_q;
    assign read_enable         = read_enable_q;
    assign read_addr           = read_addr_q;
    assign write_enable        = vld_pipe_q[L-1] ? oh_pipe_q[L-1] : 9'd0;
    assign write_addr          = addr_pipe_q[L-1];
    assign frame_buffer_select = fsel_q;
    assign generation          = gen_q;
endmodule
